// File: rtl/dbus_timer_pkg.sv
// Register map offsets and bit positions shared by the dbus timer RTL.
package dbus_timer_pkg;

    // Register offsets from the base address
    localparam int unsigned CTRL_OFS     = 0;
    localparam int unsigned PRESCALE_OFS = 1;
    localparam int unsigned RELOAD_OFS   = 2;
    localparam int unsigned COUNT_OFS    = 3;
    localparam int unsigned STATUS_OFS   = 4;
    localparam int unsigned NUM_REGS     = 5;

    // CTRL bit positions
    localparam int unsigned EN_BIT   = 0;
    localparam int unsigned AUTO_BIT = 1;
    localparam int unsigned IE_BIT   = 2;
    localparam int unsigned LOAD_BIT = 3;

    // STATUS bit positions
    localparam int unsigned TO_BIT   = 0;

endpackage

// File: rtl/dbus_timer_prescaler.sv
// Prescaler: counts 0..prescale while enabled and flags the terminal value as a tick.
module dbus_timer_prescaler #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             en,
    input  logic [WIDTH-1:0] prescale,
    output logic             tick
);

    logic [WIDTH-1:0] pcnt;

    // Held at 0 while disabled; a lowered prescale with pcnt beyond it wraps without a tick
    always_ff @(posedge Clk) begin
        if (Rst || !en) begin
            pcnt <= '0;
        end else if (pcnt >= prescale) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + WIDTH'(1);
        end
    end

    assign tick = en && (pcnt == prescale);

endmodule

// File: rtl/dbus_timer.sv
// Memory-mapped programmable down-counter timer on the lab data bus.
module dbus_timer
    import dbus_timer_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(8'h10)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0] Din,
    output logic [DATA_WIDTH-1:0] Dout,
    input  logic                  Wr,
    output logic                  Irq
);

    logic [ADDR_WIDTH-1:0] ofs;
    logic                  hit;
    logic                  we_ctrl;
    logic                  we_prescale;
    logic                  we_reload;
    logic                  we_status;
    logic                  load;
    logic                  ctrl_stop;
    logic                  tick;
    logic                  tick_eff;
    logic                  expire;

    logic                  en_q;
    logic                  auto_rl_q;
    logic                  ie_q;
    logic [DATA_WIDTH-1:0] prescale_q;
    logic [DATA_WIDTH-1:0] reload_q;
    logic [DATA_WIDTH-1:0] count_q;
    logic                  to_q;

    // Address decode: offset wraps below the base, so one compare covers both window edges
    assign ofs         = Addr - BASE_ADDR;
    assign hit         = ofs < ADDR_WIDTH'(NUM_REGS);
    assign we_ctrl     = Wr && hit && (ofs == ADDR_WIDTH'(CTRL_OFS));
    assign we_prescale = Wr && hit && (ofs == ADDR_WIDTH'(PRESCALE_OFS));
    assign we_reload   = Wr && hit && (ofs == ADDR_WIDTH'(RELOAD_OFS));
    assign we_status   = Wr && hit && (ofs == ADDR_WIDTH'(STATUS_OFS));

    // LOAD and an EN-clearing CTRL write both override a coincident tick
    assign load      = we_ctrl && Din[LOAD_BIT];
    assign ctrl_stop = we_ctrl && !Din[EN_BIT];
    assign tick_eff  = tick && en_q && !load && !ctrl_stop;
    assign expire    = tick_eff && (count_q == '0);

    dbus_timer_prescaler #(
        .WIDTH    (DATA_WIDTH)
    ) u_prescaler (
        .Clk      (Clk),
        .Rst      (Rst),
        .en       (en_q),
        .prescale (prescale_q),
        .tick     (tick)
    );

    // Register file: a software CTRL write takes precedence over the one-shot EN auto-clear
    always_ff @(posedge Clk) begin
        if (Rst) begin
            en_q       <= 1'b0;
            auto_rl_q  <= 1'b0;
            ie_q       <= 1'b0;
            prescale_q <= '0;
            reload_q   <= '0;
        end else begin
            if (we_ctrl) begin
                en_q      <= Din[EN_BIT];
                auto_rl_q <= Din[AUTO_BIT];
                ie_q      <= Din[IE_BIT];
            end else if (expire && !auto_rl_q) begin
                en_q      <= 1'b0;
            end
            if (we_prescale) begin
                prescale_q <= Din;
            end
            if (we_reload) begin
                reload_q <= Din;
            end
        end
    end

    // Down-counter: reload on LOAD, otherwise decrement per tick and reload/stop at zero
    always_ff @(posedge Clk) begin
        if (Rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= reload_q;
        end else if (tick_eff) begin
            if (count_q == '0) begin
                if (auto_rl_q) begin
                    count_q <= reload_q;
                end
            end else begin
                count_q <= count_q - DATA_WIDTH'(1);
            end
        end
    end

    // Sticky timeout flag (set beats write-1-clear) and registered interrupt
    always_ff @(posedge Clk) begin
        if (Rst) begin
            to_q <= 1'b0;
            Irq  <= 1'b0;
        end else begin
            to_q <= expire || (to_q && !(we_status && Din[TO_BIT]));
            Irq  <= to_q && ie_q;
        end
    end

    // Read mux, combinational from Addr; unmapped addresses and unused bits read 0
    always_comb begin
        Dout = '0;
        if (hit) begin
            case (ofs)
                ADDR_WIDTH'(CTRL_OFS): begin
                    Dout[EN_BIT]   = en_q;
                    Dout[AUTO_BIT] = auto_rl_q;
                    Dout[IE_BIT]   = ie_q;
                end
                ADDR_WIDTH'(PRESCALE_OFS): Dout = prescale_q;
                ADDR_WIDTH'(RELOAD_OFS):   Dout = reload_q;
                ADDR_WIDTH'(COUNT_OFS):    Dout = count_q;
                ADDR_WIDTH'(STATUS_OFS):   Dout[TO_BIT] = to_q;
                default:                   Dout = '0;
            endcase
        end
    end

endmodule
